mem_arbiter: RTL and testbench

Two-port arbiter and sequencer for the shared unified instruction/data memory in the MIPS core. It multiplexes the instruction-fetch port and the load/store data port onto the single-ported memory: combinational read, write committed on the rising clock edge. It also converts byte addresses to word indices and rejects misaligned or out-of-range accesses. The arbiter sits between the fetch/memory-stage control logic and the memory instance.

---
 rtl/mem_arb_pkg.sv | 32 +++
 rtl/mem_arb_rr.sv | 44 ++++
 rtl/mem_arbiter.sv | 107 ++++++++++
 tb/tb_mem_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the unified-memory arbiter.
package mem_arb_pkg;

    localparam int DEPTH_DEF  = 64;
    localparam int ADDR_W     = 32;
    localparam int WORD_SHIFT = 2;
    localparam int IDX_W      = ADDR_W - WORD_SHIFT;

    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_D  = 1'b1
    } owner_e;

    // Accepted command, presented to the memory in the cycle after grant.
    typedef struct packed {
        logic             valid;
        owner_e           owner;
        logic             we;
        logic [IDX_W-1:0] idx;
        logic [31:0]      wdata;
        logic             err;
    } cmd_t;

    // Response, presented on the owner's port in the cycle after access.
    typedef struct packed {
        logic        valid;
        owner_e      owner;
        logic [31:0] rdata;
        logic        err;
    } rsp_t;

endpackage

// File: rtl/mem_arb_rr.sv
// Two-way arbiter between fetch and data requests.
// MEMARB_ROUND_ROBIN_EN: alternate winners on simultaneous requests using a
// last-grant flag (data first after reset). Without it, data always wins and
// the module is purely combinational.
module mem_arb_rr (
`ifdef MEMARB_ROUND_ROBIN_EN
    input  logic clk_i,
    input  logic rst_ni,
`endif
    input  logic req_if_i,
    input  logic req_d_i,
    output logic gnt_if_o,
    output logic gnt_d_o
);

`ifdef MEMARB_ROUND_ROBIN_EN
    logic last_d_q, last_d_d;

    // Winner selection and last-grant update.
    always_comb begin
        gnt_d_o  = req_d_i & (~req_if_i | ~last_d_q);
        gnt_if_o = req_if_i & (~req_d_i | last_d_q);
        last_d_d = last_d_q;
        if (gnt_d_o) begin
            last_d_d = 1'b1;
        end else if (gnt_if_o) begin
            last_d_d = 1'b0;
        end
    end

    // Last-grant register; cleared so data wins the first contention.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            last_d_q <= 1'b0;
        end else begin
            last_d_q <= last_d_d;
        end
    end
`else
    assign gnt_d_o  = req_d_i;
    assign gnt_if_o = req_if_i & ~req_d_i;
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Fetch/data arbiter for the shared single-ported instruction/data memory.
// Pipeline: grant (N) -> memory access from CMD (N+1) -> response from RSP (N+2).
// Optional macro MEMARB_ROUND_ROBIN_EN selects round-robin arbitration.
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DEPTH = DEPTH_DEF
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_gnt_o,
    output logic        if_rvalid_o,
    output logic [31:0] if_rdata_o,
    output logic        if_err_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    output logic        d_gnt_o,
    output logic        d_rvalid_o,
    output logic [31:0] d_rdata_o,
    output logic        d_err_o,
    output logic        mem_we_o,
    output logic [31:0] mem_addr_o,
    output logic [31:0] mem_wd_o,
    input  logic [31:0] mem_rd_i
);

    localparam logic [IDX_W-1:0] DEPTH_IDX = IDX_W'(DEPTH);

    cmd_t        cmd_q, cmd_d;
    rsp_t        rsp_q, rsp_d;
    logic        arb_gnt_if, arb_gnt_d;
    logic [31:0] sel_addr;

    mem_arb_rr u_arb (
`ifdef MEMARB_ROUND_ROBIN_EN
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
`endif
        .req_if_i (if_req_i),
        .req_d_i  (d_req_i),
        .gnt_if_o (arb_gnt_if),
        .gnt_d_o  (arb_gnt_d)
    );

    // Grants are forced low while reset is asserted, whatever the requests.
    assign if_gnt_o = arb_gnt_if & rst_ni;
    assign d_gnt_o  = arb_gnt_d & rst_ni;
    assign sel_addr = d_gnt_o ? d_addr_i : if_addr_i;

    // Build the next command from the winning request, with the error check.
    always_comb begin
        cmd_d = '0;
        if (if_gnt_o || d_gnt_o) begin
            cmd_d.valid = 1'b1;
            cmd_d.owner = d_gnt_o ? OWN_D : OWN_IF;
            cmd_d.we    = d_gnt_o & d_we_i;
            cmd_d.idx   = sel_addr[ADDR_W-1:WORD_SHIFT];
            cmd_d.wdata = d_gnt_o ? d_wdata_i : 32'h0;
            cmd_d.err   = (sel_addr[WORD_SHIFT-1:0] != '0) |
                          (sel_addr[ADDR_W-1:WORD_SHIFT] >= DEPTH_IDX);
        end
    end

    // Capture the access result; stores and errors return zero data.
    always_comb begin
        rsp_d       = '0;
        rsp_d.valid = cmd_q.valid;
        rsp_d.owner = cmd_q.owner;
        rsp_d.err   = cmd_q.valid & cmd_q.err;
        if (cmd_q.valid && !cmd_q.we && !cmd_q.err) begin
            rsp_d.rdata = mem_rd_i;
        end
    end

    // CMD and RSP stage registers; reset drops anything in flight.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cmd_q <= '0;
            rsp_q <= '0;
        end else begin
            cmd_q <= cmd_d;
            rsp_q <= rsp_d;
        end
    end

    // Memory side: idle drives all zeros.
    always_comb begin
        mem_we_o   = cmd_q.valid & cmd_q.we & ~cmd_q.err;
        mem_addr_o = cmd_q.valid ? {{WORD_SHIFT{1'b0}}, cmd_q.idx} : 32'h0;
        mem_wd_o   = cmd_q.valid ? cmd_q.wdata : 32'h0;
    end

    // Response steering: only the owner's port sees the pulse.
    always_comb begin
        if_rvalid_o = rsp_q.valid & (rsp_q.owner == OWN_IF);
        d_rvalid_o  = rsp_q.valid & (rsp_q.owner == OWN_D);
        if_rdata_o  = if_rvalid_o ? rsp_q.rdata : 32'h0;
        d_rdata_o   = d_rvalid_o ? rsp_q.rdata : 32'h0;
        if_err_o    = if_rvalid_o & rsp_q.err;
        d_err_o     = d_rvalid_o & rsp_q.err;
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: directed scenarios plus random traffic,
// checked each cycle against a transaction-level model of grant order,
// two-cycle response latency and memory contents.
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        if_req, d_req, d_we;
    logic [31:0] if_addr, d_addr, d_wdata;
    logic        if_gnt, if_rvalid, if_err, d_gnt, d_rvalid, d_err, mem_we;
    logic [31:0] if_rdata, d_rdata, mem_addr, mem_wd, mem_rd;

    always #5 clk = ~clk;

    mem_arbiter dut (
        .clk_i(clk), .rst_ni(rst_n),
        .if_req_i(if_req), .if_addr_i(if_addr), .if_gnt_o(if_gnt),
        .if_rvalid_o(if_rvalid), .if_rdata_o(if_rdata), .if_err_o(if_err),
        .d_req_i(d_req), .d_we_i(d_we), .d_addr_i(d_addr), .d_wdata_i(d_wdata),
        .d_gnt_o(d_gnt), .d_rvalid_o(d_rvalid), .d_rdata_o(d_rdata), .d_err_o(d_err),
        .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_wd_o(mem_wd), .mem_rd_i(mem_rd)
    );

    // Physical memory driven only by the DUT's memory port.
    logic [31:0] env_mem [64];
    always_comb mem_rd = (mem_addr < 32'd64) ? env_mem[mem_addr[5:0]] : 32'hBAD0_BAD0;
    always @(posedge clk) if (mem_we && mem_addr < 32'd64) env_mem[mem_addr[5:0]] <= mem_wd;

    // Reference model state.
    typedef struct {
        int          g;
        bit          is_d;
        bit          we;
        bit          err;
        int          idx;
        logic [31:0] wdata;
        logic [31:0] rdata;
    } ent_t;

    ent_t        pq[$];
    logic [31:0] model_mem [64];
    bit          turn_if;
    bit          last_gi, last_gd;
    int          cyc;
    int          checks = 0;
    int          errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s cyc=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, ".if_gnt"}, 32'(if_gnt), 0);
        chk({tag, ".d_gnt"}, 32'(d_gnt), 0);
        chk({tag, ".if_rvalid"}, 32'(if_rvalid), 0);
        chk({tag, ".d_rvalid"}, 32'(d_rvalid), 0);
        chk({tag, ".if_rdata"}, if_rdata, 0);
        chk({tag, ".d_rdata"}, d_rdata, 0);
        chk({tag, ".if_err"}, 32'(if_err), 0);
        chk({tag, ".d_err"}, 32'(d_err), 0);
        chk({tag, ".mem_we"}, 32'(mem_we), 0);
        chk({tag, ".mem_addr"}, mem_addr, 0);
        chk({tag, ".mem_wd"}, mem_wd, 0);
    endtask

    function automatic bit addr_err(input logic [31:0] a);
        return (a[1:0] != 2'b00) || (a[31:2] >= 30'd64);
    endfunction

    // One clock cycle: check response, access and grant against the model.
    task automatic step();
        bit acc, ei, ed;
        ent_t e;
        @(negedge clk);
        if (pq.size() > 0 && pq[0].g == cyc - 2) begin
            e = pq.pop_front();
            chk("rsp.if_rvalid", 32'(if_rvalid), 32'(!e.is_d));
            chk("rsp.d_rvalid", 32'(d_rvalid), 32'(e.is_d));
            chk("rsp.if_rdata", if_rdata, e.is_d ? 32'h0 : e.rdata);
            chk("rsp.d_rdata", d_rdata, e.is_d ? e.rdata : 32'h0);
            if (e.is_d) chk("rsp.d_err", 32'(d_err), 32'(e.err));
            else        chk("rsp.if_err", 32'(if_err), 32'(e.err));
        end else begin
            chk("idle.rvalid", {30'h0, if_rvalid, d_rvalid}, 0);
            chk("idle.rdata", if_rdata | d_rdata, 0);
        end
        acc = 0;
        foreach (pq[i]) begin
            if (pq[i].g == cyc - 1) begin
                acc = 1;
                chk("acc.mem_addr", mem_addr, 32'(pq[i].idx));
                chk("acc.mem_we", 32'(mem_we), 32'(pq[i].we && !pq[i].err));
                if (pq[i].we) chk("acc.mem_wd", mem_wd, pq[i].wdata);
                if (!pq[i].err) begin
                    if (pq[i].we) model_mem[pq[i].idx] = pq[i].wdata;
                    else          pq[i].rdata = model_mem[pq[i].idx];
                end
            end
        end
        if (!acc) begin
            chk("idle.mem_we", 32'(mem_we), 0);
            chk("idle.mem_addr", mem_addr, 0);
            chk("idle.mem_wd", mem_wd, 0);
        end
        if (if_req && d_req) begin
`ifdef MEMARB_ROUND_ROBIN_EN
            ed = !turn_if;
`else
            ed = 1;
`endif
            ei = !ed;
        end else begin
            ed = d_req;
            ei = if_req;
        end
        if (ed) turn_if = 1;
        else if (ei) turn_if = 0;
        chk("gnt.if", 32'(if_gnt), 32'(ei));
        chk("gnt.d", 32'(d_gnt), 32'(ed));
        if (ed || ei) begin
            e.g     = cyc;
            e.is_d  = ed;
            e.we    = ed && d_we;
            e.err   = addr_err(ed ? d_addr : if_addr);
            e.idx   = int'((ed ? d_addr : if_addr) >> 2);
            e.wdata = d_wdata;
            e.rdata = 32'h0;
            pq.push_back(e);
        end
        last_gi = ei;
        last_gd = ed;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    function automatic logic [31:0] rand_addr();
        int r;
        r = $urandom_range(0, 9);
        if (r == 0) return (32'($urandom_range(0, 63)) << 2) | 32'($urandom_range(1, 3));
        if (r == 1) return 32'($urandom_range(64, 200)) << 2;
        return 32'($urandom_range(0, 63)) << 2;
    endfunction

    initial begin
        for (int i = 0; i < 64; i++) begin
            env_mem[i]   = $urandom;
            model_mem[i] = env_mem[i];
        end
        env_mem[5] = 32'hDEADBEEF;  model_mem[5] = 32'hDEADBEEF;
        env_mem[16] = 32'h0;        model_mem[16] = 32'h0;
        rst_n = 0; if_req = 1; d_req = 1; d_we = 0;
        if_addr = 0; d_addr = 0; d_wdata = 0;
        turn_if = 0; cyc = 0;
        #3 chk_all_zero("reset");
        @(posedge clk); #1;
        if_req = 0; d_req = 0;
        @(posedge clk); #1;
        rst_n = 1;

        // Single fetch of word 5.
        if_req = 1; if_addr = 32'h14;
        step();
        if_req = 0;
        step();
        chk("single.mem_addr_prev_cycle", 32'(pq.size()), 1);
        step();
        step();

        // Store then load of 0x20.
        d_req = 1; d_we = 1; d_addr = 32'h20; d_wdata = 32'h12345678;
        step();
        d_we = 0; d_wdata = 32'h0;
        step();
        d_req = 0;
        repeat (3) step();
        chk("store_load.mem8", env_mem[8], 32'h12345678);

        // Contention for four cycles.
        if_req = 1; if_addr = 32'h4; d_req = 1; d_we = 0; d_addr = 32'h8;
        repeat (4) step();
        if_req = 0; d_req = 0;
        repeat (3) step();

        // Error cases.
        d_req = 1; d_we = 1; d_addr = 32'h22; d_wdata = 32'hFFFF_FFFF;
        step();
        d_req = 0; d_we = 0;
        if_req = 1; if_addr = 32'h100;
        step();
        if_req = 0;
        repeat (3) step();

        // Full-throughput fetch burst.
        for (int i = 0; i < 8; i++) begin
            if_req = 1; if_addr = 32'(i * 4);
            step();
        end
        if_req = 0;
        repeat (3) step();

        // Reset while a store is in flight.
        d_req = 1; d_we = 1; d_addr = 32'h40; d_wdata = 32'hCAFEF00D;
        step();
        rst_n = 0; if_req = 1; d_req = 1; d_we = 0;
        pq.delete();
        turn_if = 0;
        #2 chk_all_zero("midreset");
        repeat (2) begin
            @(posedge clk); #1;
            chk_all_zero("midreset_hold");
        end
        if_req = 0; d_req = 0;
        rst_n = 1;
        repeat (3) step();
        chk("midreset.mem16", env_mem[16], 32'h0);

        // Random traffic.
        for (int c = 0; c < 400; c++) begin
            if (!if_req) begin
                if_req = 1'($urandom_range(0, 1)); if_addr = rand_addr();
            end else if ($urandom_range(0, 15) == 0) begin
                if_req = 0;
            end
            if (!d_req) begin
                d_req = 1'($urandom_range(0, 1)); d_we = 1'($urandom_range(0, 1));
                d_addr = rand_addr(); d_wdata = $urandom;
            end else if ($urandom_range(0, 15) == 0) begin
                d_req = 0;
            end
            step();
            if (last_gi) if_req = 0;
            if (last_gd) d_req = 0;
        end
        if_req = 0; d_req = 0;
        repeat (4) step();

        for (int i = 0; i < 64; i++) chk("final.mem", env_mem[i], model_mem[i]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
